sram_arbiter: RTL and testbench

//  Three-way arbiter/sequencer for the single 512K external SRAM. Sits between requesters
//  (video fetch, Z80 CPU, aux = disk-image/ROM loader) and the SRAM pins.

---
 rtl/sram_arbiter_if.sv | 53 +++++
 rtl/sram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-pin bundle for the external SRAM arbiter.
// The slave modport is the arbiter's view of the bundle; the master modport is the requester/pin side.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 19
) ();
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [7:0]        vid_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [7:0]        aux_wdata;
  logic              aux_ack;
  logic [7:0]        aux_rdata;

  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wdata;
  logic [7:0]        sram_din;
  logic              sram_d_oe;
  logic              sram_we_n;
  logic              busy;

  modport slave (
    input  vid_req, vid_addr,
    output vid_ack, vid_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_ack, aux_rdata,
    output sram_addr, sram_wdata, sram_d_oe, sram_we_n, busy,
    input  sram_din
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_ack, vid_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_ack, aux_rdata,
    input  sram_addr, sram_wdata, sram_d_oe, sram_we_n, busy,
    output sram_din
  );
endinterface

// File: rtl/sram_arbiter.sv
// Three-way (video/CPU/aux) arbiter and strobe sequencer for the single external SRAM.
// Priority vid > cpu > aux, with aux promoted over CPU after AUX_STARVE consecutive CPU grants.
module sram_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned ACC_CYCLES = 2,
  parameter int unsigned AUX_STARVE = 16
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(ACC_CYCLES + 1);
  localparam int unsigned STV_W = $clog2(AUX_STARVE + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  localparam logic [1:0] OWN_VID = 2'd0;
  localparam logic [1:0] OWN_CPU = 2'd1;
  localparam logic [1:0] OWN_AUX = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(AUX_STARVE);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              oe_q, oe_d;
  logic              we_n_q, we_n_d;
  logic              vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d, aux_ack_q, aux_ack_d;
  logic [7:0]        vid_rdata_q, vid_rdata_d, cpu_rdata_q, cpu_rdata_d, aux_rdata_q, aux_rdata_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              busy_q, busy_d;

  // Arbitration, strobe sequencing and ack/read-data generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    oe_d        = oe_q;
    we_n_d      = 1'b1;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    aux_ack_d   = 1'b0;
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    starve_d    = starve_q;

    case (state_q)
      S_IDLE: begin
        oe_d = 1'b0;
        if (!bus.aux_req) starve_d = '0;
        if (bus.vid_req) begin
          state_d = S_SETUP;
          owner_d = OWN_VID;
          we_d    = 1'b0;
          addr_d  = bus.vid_addr;
        end else if (bus.aux_req && (starve_q == STV_MAX || !bus.cpu_req)) begin
          state_d  = S_SETUP;
          owner_d  = OWN_AUX;
          we_d     = bus.aux_we;
          addr_d   = bus.aux_addr;
          wdata_d  = bus.aux_wdata;
          oe_d     = bus.aux_we;
          starve_d = '0;
        end else if (bus.cpu_req) begin
          state_d = S_SETUP;
          owner_d = OWN_CPU;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          oe_d    = bus.cpu_we;
          // aux pending here implies starve_q < STV_MAX, so this saturates naturally
          if (bus.aux_req) starve_d = starve_q + STV_W'(1);
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
        we_n_d  = !we_q;
      end
      S_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_END;
          case (owner_q)
            OWN_VID: begin
              vid_ack_d   = 1'b1;
              vid_rdata_d = bus.sram_din;
            end
            OWN_CPU: begin
              cpu_ack_d = 1'b1;
              if (!we_q) cpu_rdata_d = bus.sram_din;
            end
            OWN_AUX: begin
              aux_ack_d = 1'b1;
              if (!we_q) aux_rdata_d = bus.sram_din;
            end
            default: ;
          endcase
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          we_n_d = !we_q;
        end
      end
      S_END: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_VID;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      aux_ack_q   <= 1'b0;
      vid_rdata_q <= 8'hFF;
      cpu_rdata_q <= 8'hFF;
      aux_rdata_q <= 8'hFF;
      starve_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      aux_ack_q   <= aux_ack_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
      starve_q    <= starve_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_d_oe  = oe_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.vid_ack    = vid_ack_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.aux_ack    = aux_ack_q;
  assign bus.vid_rdata  = vid_rdata_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.aux_rdata  = aux_rdata_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM model, ack scoreboard, per-scenario tasks.
module tb_sram_arbiter;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned ACC    = 2;
  localparam int unsigned STARVE = 16;
  localparam int LAT    = 2 + ACC;
  localparam int PERIOD = ACC + 3;
  localparam logic [1:0] P_VID = 2'd0;
  localparam logic [1:0] P_CPU = 2'd1;
  localparam logic [1:0] P_AUX = 2'd2;

  typedef struct packed {
    logic [1:0] port;
    logic       chk;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] ref_wr [int];

  sram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sram_arbiter #(.ADDR_W(ADDR_W), .ACC_CYCLES(ACC), .AUX_STARVE(STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_pat(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[18:11] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [ADDR_W-1:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return init_pat(a);
  endfunction

  // Asynchronous-read SRAM; writes land while the strobe is low
  assign bus.sram_din = mem[bus.sram_addr];
  always @(posedge clk) if (!bus.sram_we_n) mem[bus.sram_addr] <= bus.sram_wdata;

  // Every ack pops the scoreboard; owner and read data must match
  always @(negedge clk) begin : monitor
    int n;
    logic [1:0] p;
    logic [7:0] d;
    exp_t e;
    n = {31'd0, bus.vid_ack} + {31'd0, bus.cpu_ack} + {31'd0, bus.aux_ack};
    if (!rst && n != 0) begin
      p = bus.vid_ack ? P_VID : (bus.cpu_ack ? P_CPU : P_AUX);
      d = bus.vid_ack ? bus.vid_rdata : (bus.cpu_ack ? bus.cpu_rdata : bus.aux_rdata);
      checks++;
      if (n != 1) begin
        errors++;
        $display("FAIL single_ack: %0d acks high, required 1", n);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: ack on port %0d with nothing expected", p);
      end else begin
        e = sb.pop_front();
        if (p !== e.port) begin
          errors++;
          $display("FAIL sb_port: ack port %0d, required %0d", p, e.port);
        end else if (e.chk && d !== e.data) begin
          errors++;
          $display("FAIL sb_data: port %0d rdata %02h, required %02h", p, d, e.data);
        end
      end
    end
  end

  task automatic run_cpu(input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] wdata,
                         input logic mutate, output int ack_k, output int wen_low, output int bus_bad);
    exp_t e;
    e.port = P_CPU;
    e.chk  = !we;
    e.data = we ? 8'h00 : exp_rd(addr);
    sb.push_back(e);
    if (we) ref_wr[int'(addr)] = wdata;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    ack_k = 0; wen_low = 0; bus_bad = 0;
    for (int k = 1; k <= 4 * LAT; k++) begin
      @(negedge clk);
      if (k == 1 && mutate) begin
        bus.cpu_addr  = ~addr;
        bus.cpu_wdata = ~wdata;
      end
      if (!bus.sram_we_n) wen_low++;
      if (bus.sram_addr !== addr || (we && (bus.sram_wdata !== wdata || bus.sram_d_oe !== 1'b1)))
        bus_bad++;
      if (bus.cpu_ack) begin
        ack_k = k;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  task automatic test_reset();
    bus.vid_req = 1'b1; bus.cpu_req = 1'b1; bus.aux_req = 1'b1;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.vid_ack, bus.cpu_ack, bus.aux_ack} !== 3'b000) begin
        errors++; $display("FAIL reset_ack: acks=%b required 000", {bus.vid_ack, bus.cpu_ack, bus.aux_ack});
      end
      checks++;
      if (bus.sram_we_n !== 1'b1 || bus.sram_d_oe !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL reset_ctrl: we_n=%b d_oe=%b busy=%b required 1 0 0",
                           bus.sram_we_n, bus.sram_d_oe, bus.busy);
      end
      checks++;
      if ({bus.vid_rdata, bus.cpu_rdata, bus.aux_rdata} !== 24'hFFFFFF) begin
        errors++; $display("FAIL reset_rdata: %02h %02h %02h required FF FF FF",
                           bus.vid_rdata, bus.cpu_rdata, bus.aux_rdata);
      end
      checks++;
      if (bus.sram_addr !== '0 || bus.sram_wdata !== 8'h00) begin
        errors++; $display("FAIL reset_bus: addr=%05h wdata=%02h required 0 0", bus.sram_addr, bus.sram_wdata);
      end
    end
    bus.vid_req = 1'b0; bus.cpu_req = 1'b0; bus.aux_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_write_read();
    int k, wl, bb;
    run_cpu(1'b1, 19'h12345, 8'hA5, 1'b0, k, wl, bb);
    checks++;
    if (k !== LAT) begin errors++; $display("FAIL wr_latency: ack at %0d, required %0d", k, LAT); end
    checks++;
    if (wl !== ACC) begin errors++; $display("FAIL wr_we_low: %0d clks, required %0d", wl, ACC); end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL wr_bus: %0d bad cycles, required 0", bb); end
    @(negedge clk);
    run_cpu(1'b0, 19'h12345, 8'h00, 1'b0, k, wl, bb);
    checks++;
    if (k !== LAT || wl !== 0) begin
      errors++; $display("FAIL rd_timing: ack at %0d we_low %0d, required %0d 0", k, wl, LAT);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_hold: %02h required A5", bus.cpu_rdata); end
  endtask

  task automatic test_priority();
    int cv, cc, ca;
    exp_t e;
    e.chk = 1'b1;
    e.port = P_VID; e.data = exp_rd(19'h01111); sb.push_back(e);
    e.port = P_CPU; e.data = exp_rd(19'h02222); sb.push_back(e);
    e.port = P_AUX; e.data = exp_rd(19'h03333); sb.push_back(e);
    bus.vid_req = 1'b1; bus.vid_addr = 19'h01111;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h02222;
    bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 19'h03333;
    cv = 0; cc = 0; ca = 0;
    for (int k = 1; k <= 8 * PERIOD; k++) begin
      @(negedge clk);
      if (bus.vid_ack) begin cv = k; bus.vid_req = 1'b0; end
      if (bus.cpu_ack) begin cc = k; bus.cpu_req = 1'b0; end
      if (bus.aux_ack) begin ca = k; bus.aux_req = 1'b0; end
      if (cv != 0 && cc != 0 && ca != 0) break;
    end
    bus.vid_req = 1'b0; bus.cpu_req = 1'b0; bus.aux_req = 1'b0;
    checks++;
    if (cv !== LAT) begin errors++; $display("FAIL prio_vid: ack at %0d, required %0d", cv, LAT); end
    checks++;
    if (cc !== LAT + PERIOD || ca !== LAT + 2 * PERIOD) begin
      errors++; $display("FAIL prio_seq: cpu %0d aux %0d, required %0d %0d", cc, ca, LAT + PERIOD, LAT + 2 * PERIOD);
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    localparam int TOTAL = 2 * (STARVE + 1) + 1;
    logic [1:0] seq[$];
    logic [1:0] ord[$];
    exp_t e;
    int n_aux;
    logic vid_done;
    for (int i = 0; i < TOTAL; i++) begin
      if (i == 5) ord.push_back(P_VID);
      else if (i == STARVE + 1 || i == TOTAL - 1) ord.push_back(P_AUX);
      else ord.push_back(P_CPU);
    end
    foreach (ord[i]) begin
      e.port = ord[i];
      e.chk  = 1'b1;
      e.data = (ord[i] == P_VID) ? exp_rd(19'h05555) : (ord[i] == P_CPU) ? exp_rd(19'h00100) : exp_rd(19'h40000);
      sb.push_back(e);
    end
    bus.vid_addr = 19'h05555;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h00100;
    bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 19'h40000;
    vid_done = 1'b0;
    for (int k = 0; k < (TOTAL + 4) * PERIOD; k++) begin
      @(negedge clk);
      if (bus.vid_ack) begin seq.push_back(P_VID); bus.vid_req = 1'b0; vid_done = 1'b1; end
      if (bus.cpu_ack) seq.push_back(P_CPU);
      if (bus.aux_ack) seq.push_back(P_AUX);
      if (seq.size() == 5 && !vid_done) bus.vid_req = 1'b1;
      if (seq.size() >= TOTAL) break;
    end
    bus.cpu_req = 1'b0; bus.aux_req = 1'b0; bus.vid_req = 1'b0;
    checks++;
    if (seq.size() != TOTAL) begin
      errors++; $display("FAIL starve_count: %0d acks, required %0d", seq.size(), TOTAL);
    end else begin
      n_aux = 0;
      foreach (seq[i]) if (seq[i] == P_AUX) n_aux++;
      checks++;
      if (seq[5] !== P_VID) begin errors++; $display("FAIL starve_vid: slot 5 port %0d, required %0d", seq[5], P_VID); end
      checks++;
      if (seq[STARVE + 1] !== P_AUX || seq[TOTAL - 1] !== P_AUX || n_aux != 2) begin
        errors++; $display("FAIL starve_aux: ports %0d %0d count %0d, required 2 2 2",
                           seq[STARVE + 1], seq[TOTAL - 1], n_aux);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_latch();
    int k, wl, bb;
    run_cpu(1'b1, 19'h0ABCD, 8'h5A, 1'b1, k, wl, bb);
    checks++;
    if (k !== LAT || wl !== ACC || bb !== 0) begin
      errors++; $display("FAIL latch_wr: ack %0d we_low %0d bad %0d, required %0d %0d 0", k, wl, bb, LAT, ACC);
    end
    @(negedge clk);
    run_cpu(1'b0, 19'h0ABCD, 8'h00, 1'b0, k, wl, bb);
    @(negedge clk);
    checks++;
    if (bus.cpu_rdata !== 8'h5A) begin errors++; $display("FAIL latch_rd: %02h required 5A", bus.cpu_rdata); end
    run_cpu(1'b0, ~19'h0ABCD, 8'h00, 1'b0, k, wl, bb);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k, wl, bb;
    logic seen;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 19'h00777; bus.cpu_wdata = 8'h77;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.sram_we_n !== 1'b0) begin errors++; $display("FAIL abort_pre: we_n=%b required 0", bus.sram_we_n); end
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sram_we_n !== 1'b1 || bus.cpu_ack !== 1'b0 || bus.busy !== 1'b0 || bus.sram_d_oe !== 1'b0) begin
      errors++; $display("FAIL abort_rst: we_n=%b ack=%b busy=%b d_oe=%b required 1 0 0 0",
                         bus.sram_we_n, bus.cpu_ack, bus.busy, bus.sram_d_oe);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_noack: ack/busy seen after abort, required none"); end
    run_cpu(1'b0, 19'h01234, 8'h00, 1'b0, k, wl, bb);
    checks++;
    if (k !== LAT) begin errors++; $display("FAIL abort_next: ack at %0d, required %0d", k, LAT); end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = init_pat(ADDR_W'(i));
    rst = 1'b1;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.aux_req = 1'b0; bus.aux_we = 1'b0; bus.aux_addr = '0; bus.aux_wdata = '0;
    test_reset();
    test_cpu_write_read();
    test_priority();
    test_starvation();
    test_latch();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d entries, required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
